intc32bus: RTL

INTC32BUS -- requirements
Module: intc32bus

---
 rtl/intc32bus.sv | 106 ++++++++++
 1 files changed

// File: rtl/intc32bus.sv
// intc32bus: eight-source edge-triggered interrupt controller on a 32-bit word bus.
// Registers: PEND (W1C), MASK, CON (global enable), ID (priority/acknowledge), OVF (sticky W1C).
module intc32bus #(
    parameter logic [23:0] INTC_BASE = 24'h5A3F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        wren,
    input  logic        rden,
    input  logic [23:0] addr,
    input  logic [7:0]  evt_in,
    output logic        irq
);

    localparam logic [23:0] A_PEND = INTC_BASE;
    localparam logic [23:0] A_MASK = INTC_BASE + 24'd1;
    localparam logic [23:0] A_CON  = INTC_BASE + 24'd2;
    localparam logic [23:0] A_ID   = INTC_BASE + 24'd3;
    localparam logic [23:0] A_OVF  = INTC_BASE + 24'd4;

    logic [7:0] evt_q;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] ovf;
    logic       con_en;

    logic [7:0] evt_edge;
    logic [7:0] active;
    logic [2:0] id_idx;
    logic [7:0] pend_clr;
    logic [7:0] ovf_clr;
    logic [7:0] ovf_set;
    logic       wr_pend, wr_mask, wr_con, wr_id, wr_ovf;

    // Only din[7:0] (and din[0] for CON) carry meaning; upper bits are ignored by design.
    logic unused_din;
    assign unused_din = ^din[31:8];

    assign evt_edge = evt_in & ~evt_q;
    assign active   = pend & mask;

    assign wr_pend = wren && (addr == A_PEND);
    assign wr_mask = wren && (addr == A_MASK);
    assign wr_con  = wren && (addr == A_CON);
    assign wr_id   = wren && (addr == A_ID);
    assign wr_ovf  = wren && (addr == A_OVF);

    // Lowest-numbered enabled pending source wins the ID field.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        id_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) id_idx = 3'(i);
        end
    end

    // Clear requests into PEND: W1C write to PEND or one-hot acknowledge via ID.
    always_comb begin
        pend_clr = 8'h00;
        if (wr_pend) pend_clr = din[7:0];
        if (wr_id)   pend_clr[din[2:0]] = 1'b1;
    end

    // An edge on a still-pending source that is not being cleared this cycle is an overflow.
    assign ovf_set = evt_edge & pend & ~pend_clr;
    assign ovf_clr = wr_ovf ? din[7:0] : 8'h00;

    // Register state; edge sets are ORed in after clears so a same-cycle set always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q  <= 8'h00;
            pend   <= 8'h00;
            mask   <= 8'h00;
            ovf    <= 8'h00;
            con_en <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            evt_q <= evt_in;
            pend  <= (pend & ~pend_clr) | evt_edge;
            ovf   <= (ovf & ~ovf_clr) | ovf_set;
            if (wr_mask) mask   <= din[7:0];
            if (wr_con)  con_en <= din[0];
        end
    end

    // Interrupt request is a pure function of registered state.
    assign irq = con_en & (|active);

    // Read mux: zero unless a mapped register is being read.
    always_comb begin
        dout = 32'h0;
        if (rden) begin
            case (addr)
                A_PEND:  dout = {24'h0, pend};
                A_MASK:  dout = {24'h0, mask};
                A_CON:   dout = {31'h0, con_en};
                A_ID:    dout = {|active, 28'h0, id_idx};
                A_OVF:   dout = {24'h0, ovf};
                default: dout = 32'h0;
            endcase
        end
    end

endmodule
